magic_square_stream_checker: RTL and testbench
==============================================

Name: magic_square_stream_checker

Overview:
- Sequential, parametrised successor to the combinational 3x3 magic-square checker (uniqueness, row/column/diagonal sums).
- Accepts an N x N square streamed one cell per valid/ready handshake in row-major order.
- Accumulates row, column and diagonal sums and tracks duplicates while cells arrive, then runs an N-cycle compare phase.
- Reports magic status, uniqueness, sum equality and the magic constant. Sits between the cell source (keypad/ROM) and the display/result logic.

Parameters:
- N, 3, square side length (N >= 2); cells per square = N*N.
- W, 4, cell value width in bits (unsigned).
- SW, derived = $clog2(N*(2**W-1)+1), width of every line sum; not overridable.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  begin a new square; honoured only in IDLE.
- cell_valid  input  1  cell_data is valid this cycle.
- cell_data  input  W  cell value, row-major order.
- cell_ready  output  1  high only in LOAD.
- busy  output  1  high in LOAD, CHECK and DONE.
- done  output  1  one-cycle pulse when results update.
- it_is_magic  output  1  all_unique & sums_equal (& range_ok when enabled).
- all_unique  output  1  no value occurred twice.
- sums_equal  output  1  all N rows, N columns and both diagonals equal the row-0 sum.
- magic_constant  output  SW  row-0 sum.

Behaviour:
- Reset (asynchronous): state=IDLE; cell_ready, busy, done, it_is_magic, all_unique and sums_equal = 0; magic_constant=0; accumulators, cell index and seen bitmap cleared.
- States: IDLE -> LOAD on start. LOAD -> CHECK the cycle after the N*N-th accepted cell. CHECK -> DONE after N cycles. DONE -> IDLE unconditionally after 1 cycle.
- Entering LOAD: clear all accumulators, dup flag and seen bitmap in the same cycle start is sampled. The first cell can be accepted on the following cycle.
- Accept rule: transfer occurs when cell_valid & cell_ready. With cell_valid low, state holds and nothing changes. cell_data is ignored outside a transfer.
- On transfer k (0..N*N-1), with r=k/N and c=k%N:
  - row_sum[r] += v; col_sum[c] += v.
  - diag += v if r==c; anti += v if r+c==N-1.
  - dup set (sticky) if seen[v] is already 1; then seen[v]=1.
- Sums are zero-extended to SW; no overflow by construction.
- CHECK step i (0..N-1): mismatch sticky-set if row_sum[i]!=row_sum[0] or col_sum[i]!=row_sum[0]. Step 0 additionally compares diag and anti against row_sum[0].
- Latency: done asserts exactly N+1 cycles after the clock edge accepting the last cell.
- Result registers (it_is_magic, all_unique, sums_equal, magic_constant) load on entry to DONE. They hold through IDLE and the next LOAD/CHECK until the next DONE.
- start while busy: ignored, no restart.
- start in the DONE cycle: ignored.
- start in the same cycle the FSM returns to IDLE: honoured on the next sampled cycle only.
- Reset mid-LOAD/CHECK: immediate return to IDLE, no done pulse, result outputs cleared to 0.

Optional Feature:
- Macro MAGIC_RANGE_CHECK_EN.
- Defined: an extra sticky range_err flag is set on any accepted cell with v==0 or v>N*N. it_is_magic additionally requires !range_err (normal magic square 1..N*N). Port range_ok (output, 1) is added, with reset value 0 and updating at DONE.
- Undefined: no range logic and no range_ok port; any W-bit value is legal.

Decomposition:
- Shared package magic_pkg:
  - state enum (IDLE, LOAD, CHECK, DONE);
  - function sum_width(N, W);
  - localparam defaults N_DEF=3, W_DEF=4.
- One sub-module, dup_tracker:
  - contains the 2**W-bit seen bitmap, clear, and the mark/query logic;
  - outputs a dup_hit flag per transfer.
- Sum accumulators, index counter and FSM stay in the top module.

Test Plan:
- N=3, W=4, cells 2,7,6,9,5,1,4,3,8 back-to-back -> done at 4 cycles after last cell; it_is_magic=1, all_unique=1, sums_equal=1, magic_constant=15.
- Cells 6,1,8,7,5,3,2,9,4 with cell_valid dropped for 2 cycles after cells 3 and 7 -> cell_ready stays 1, no extra accepts; same results, magic_constant=15.
- Cells 9,2,4,6,1,7,3,7,9 -> all_unique=0, sums_equal=0, it_is_magic=0, magic_constant=15.
- All nine cells 0 -> sums_equal=1, all_unique=0, it_is_magic=0, magic_constant=0. With MAGIC_RANGE_CHECK_EN, range_ok=0.
- Assert reset after cell 5 of a Lo Shu load, then start and a full valid load -> no done before the reload; final result it_is_magic=1. start pulsed during CHECK is ignored, giving exactly one done.
- N=4, W=5, Durer square 16,3,2,13,5,10,11,8,9,6,7,12,4,15,14,1 -> it_is_magic=1, magic_constant=34, done 5 cycles after last cell.

Source files
------------

// File: rtl/magic_square_stream_checker_pkg.sv
// Shared definitions for the streaming magic-square checker.
//   state_t    : controller states (IDLE, LOAD, CHECK, DONE)
//   sum_width  : bits needed to hold one line sum of n cells of w bits each
//   N_DEF/W_DEF: default square side and cell width
package magic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_DEF = 3;
    localparam int W_DEF = 4;

    // Width of a sum of n values, each at most 2**w-1.
    function automatic int sum_width(input int n, input int w);
        return $clog2(n * int'((32'd1 << w) - 32'd1) + 1);
    endfunction

endpackage

// File: rtl/magic_square_stream_checker_dup_tracker.sv
// Duplicate-value tracker: one bit per possible cell value.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   clear        : wipe the bitmap (start of a new square)
//   mark         : a cell transfer happens this cycle
//   value        : value of the transferred cell
//   dup_hit      : this transfer repeats a value already seen since clear
module dup_tracker
    import magic_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         mark,
    input  logic [W-1:0] value,
    output logic         dup_hit
);

    localparam int DEPTH = int'(32'd1 << W);

    logic [DEPTH-1:0] seen_r;

    // Query the bitmap before this transfer marks it.
    always_comb begin
        dup_hit = mark & seen_r[value];
    end

    // Bitmap update: clear on a new square, otherwise set the bit of each accepted value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_r <= {DEPTH{1'b0}};
        end else if (clear) begin
            seen_r <= {DEPTH{1'b0}};
        end else if (mark) begin
            seen_r[value] <= 1'b1;
        end else begin
            seen_r <= seen_r;
        end
    end

endmodule

// File: rtl/magic_square_stream_checker.sv
// Streaming N x N magic-square checker. Cells arrive row-major through a
// valid/ready handshake; line sums and duplicate tracking build up during
// LOAD, then CHECK compares one row/column pair per cycle against row 0.
// Ports:
//   clock, reset      : clock, asynchronous active-high reset
//   start             : begin a new square (honoured in IDLE only)
//   cell_valid/ready  : cell handshake; cell_data is the cell value
//   busy              : LOAD, CHECK or DONE
//   done              : one-cycle pulse when the result outputs update
//   it_is_magic, all_unique, sums_equal, magic_constant : held results
// Optional: define MAGIC_RANGE_CHECK_EN to require cells in 1..N*N and add
// the range_ok output.
module magic_square_stream_checker
    import magic_pkg::*;
#(
    parameter  int N  = N_DEF,
    parameter  int W  = W_DEF,
    localparam int SW = sum_width(N, W)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          cell_valid,
    input  logic [W-1:0]  cell_data,
    output logic          cell_ready,
    output logic          busy,
    output logic          done,
    output logic          it_is_magic,
    output logic          all_unique,
    output logic          sums_equal,
    output logic [SW-1:0] magic_constant
`ifdef MAGIC_RANGE_CHECK_EN
    ,
    output logic          range_ok
`endif
);

    localparam int NN = N * N;
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(NN + 1);
    localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);
    localparam logic [RW-1:0] ZERO_IDX = {RW{1'b0}};
    localparam logic [RW:0]   ANTI_SUM = (RW + 1)'(N - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NN);

    state_t        state_r, state_nxt_s;
    logic [RW-1:0] row_idx_r, col_idx_r, chk_idx_r;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [SW-1:0] row_sum_r [N];
    logic [SW-1:0] col_sum_r [N];
    logic [SW-1:0] diag_r, anti_r, val_s;
    logic          dup_r, mismatch_r, dup_hit_s;
    logic          xfer_s, clear_s, chk_last_s, step_mis_s, anti_hit_s;
    logic          cell_ready_nxt_s, busy_nxt_s;
`ifdef MAGIC_RANGE_CHECK_EN
    logic          range_err_r, range_bad_s;
`endif

    // Handshake, clear and index decodes.
    always_comb begin
        xfer_s     = cell_valid & cell_ready;
        clear_s    = (state_r == IDLE) & start;
        chk_last_s = (state_r == CHECK) & (chk_idx_r == LAST_IDX);
        anti_hit_s = (({1'b0, row_idx_r} + {1'b0, col_idx_r}) == ANTI_SUM);
        val_s      = SW'(cell_data);
`ifdef MAGIC_RANGE_CHECK_EN
        range_bad_s = (cell_data == {W{1'b0}}) | (32'(cell_data) > 32'(NN));
`endif
    end

    // Accepted-cell count for the cycle after this one.
    always_comb begin
        if (clear_s) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (xfer_s) begin
            cnt_nxt_s = cnt_r + 1'b1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // One CHECK step: row i and column i against row 0; step 0 adds both diagonals.
    always_comb begin
        step_mis_s = 1'b0;
        if (state_r == CHECK) begin
            step_mis_s = (row_sum_r[chk_idx_r] != row_sum_r[0]) |
                         (col_sum_r[chk_idx_r] != row_sum_r[0]);
            if (chk_idx_r == ZERO_IDX) begin
                step_mis_s = step_mis_s | (diag_r != row_sum_r[0]) | (anti_r != row_sum_r[0]);
            end else begin
                step_mis_s = step_mis_s;
            end
        end else begin
            step_mis_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; LOAD waits one cycle after the last cell before CHECK.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = start ? LOAD : IDLE;
            LOAD:    state_nxt_s = (cnt_r == CNT_FULL) ? CHECK : LOAD;
            CHECK:   state_nxt_s = (chk_idx_r == LAST_IDX) ? DONE : CHECK;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs, computed one cycle early so the ports come straight from flops.
    always_comb begin
        busy_nxt_s       = (state_nxt_s != IDLE);
        cell_ready_nxt_s = (state_nxt_s == LOAD) & (cnt_nxt_s != CNT_FULL);
    end

    // Duplicate tracking over the full W-bit value range.
    dup_tracker #(.W(W)) u_dup (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear_s),
        .mark    (xfer_s),
        .value   (cell_data),
        .dup_hit (dup_hit_s)
    );

    // Accumulators, cell indices, sticky flags and the CHECK step counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset || clear_s) begin
            for (int i = 0; i < N; i++) begin
                row_sum_r[i] <= {SW{1'b0}};
                col_sum_r[i] <= {SW{1'b0}};
            end
            diag_r     <= {SW{1'b0}};
            anti_r     <= {SW{1'b0}};
            row_idx_r  <= ZERO_IDX;
            col_idx_r  <= ZERO_IDX;
            chk_idx_r  <= ZERO_IDX;
            cnt_r      <= {CW{1'b0}};
            dup_r      <= 1'b0;
            mismatch_r <= 1'b0;
`ifdef MAGIC_RANGE_CHECK_EN
            range_err_r <= 1'b0;
`endif
        end else if (xfer_s) begin
            row_sum_r[row_idx_r] <= row_sum_r[row_idx_r] + val_s;
            col_sum_r[col_idx_r] <= col_sum_r[col_idx_r] + val_s;
            if (row_idx_r == col_idx_r) begin
                diag_r <= diag_r + val_s;
            end
            if (anti_hit_s) begin
                anti_r <= anti_r + val_s;
            end
            dup_r <= dup_r | dup_hit_s;
            cnt_r <= cnt_nxt_s;
`ifdef MAGIC_RANGE_CHECK_EN
            range_err_r <= range_err_r | range_bad_s;
`endif
            // Row-major walk without a divider: wrap the column, bump the row.
            if (col_idx_r == LAST_IDX) begin
                col_idx_r <= ZERO_IDX;
                row_idx_r <= row_idx_r + 1'b1;
            end else begin
                col_idx_r <= col_idx_r + 1'b1;
            end
        end else if (state_r == CHECK) begin
            mismatch_r <= mismatch_r | step_mis_s;
            chk_idx_r  <= chk_last_s ? ZERO_IDX : chk_idx_r + 1'b1;
        end
    end

    // Registered outputs; results load on entry to DONE and hold until the next DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cell_ready     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            it_is_magic    <= 1'b0;
            all_unique     <= 1'b0;
            sums_equal     <= 1'b0;
            magic_constant <= {SW{1'b0}};
`ifdef MAGIC_RANGE_CHECK_EN
            range_ok       <= 1'b0;
`endif
        end else begin
            cell_ready <= cell_ready_nxt_s;
            busy       <= busy_nxt_s;
            done       <= chk_last_s;
            if (chk_last_s) begin
                // The last CHECK step has not been folded into mismatch_r yet.
                all_unique     <= ~dup_r;
                sums_equal     <= ~(mismatch_r | step_mis_s);
                magic_constant <= row_sum_r[0];
`ifdef MAGIC_RANGE_CHECK_EN
                range_ok       <= ~range_err_r;
                it_is_magic    <= ~dup_r & ~(mismatch_r | step_mis_s) & ~range_err_r;
`else
                it_is_magic    <= ~dup_r & ~(mismatch_r | step_mis_s);
`endif
            end
        end
    end

endmodule

// File: tb/tb_magic_square_stream_checker.sv
`timescale 1ns/1ps
module tb_magic_square_stream_checker;
    import magic_pkg::*;

    localparam int SW3 = sum_width(3, 4);
    localparam int SW4 = sum_width(4, 5);
    localparam int BIG = 1000000000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start3 = 1'b0, valid3 = 1'b0;
    logic [3:0] data3 = 4'd0;
    logic ready3, busy3, done3, magic3, uniq3, eq3;
    logic [SW3-1:0] mc3;
    logic start4 = 1'b0, valid4 = 1'b0;
    logic [4:0] data4 = 5'd0;
    logic ready4, busy4, done4, magic4, uniq4, eq4;
    logic [SW4-1:0] mc4;
`ifdef MAGIC_RANGE_CHECK_EN
    logic rok3, rok4;
`endif

    always #5 clock = ~clock;

    magic_square_stream_checker #(.N(3), .W(4)) dut3 (
        .clock(clock), .reset(reset), .start(start3), .cell_valid(valid3),
        .cell_data(data3), .cell_ready(ready3), .busy(busy3), .done(done3),
        .it_is_magic(magic3), .all_unique(uniq3), .sums_equal(eq3),
        .magic_constant(mc3)
`ifdef MAGIC_RANGE_CHECK_EN
        , .range_ok(rok3)
`endif
    );

    magic_square_stream_checker #(.N(4), .W(5)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .cell_valid(valid4),
        .cell_data(data4), .cell_ready(ready4), .busy(busy4), .done(done4),
        .it_is_magic(magic4), .all_unique(uniq4), .sums_equal(eq4),
        .magic_constant(mc4)
`ifdef MAGIC_RANGE_CHECK_EN
        , .range_ok(rok4)
`endif
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected-behaviour model, index 0 = 3x3 instance, 1 = 4x4 instance.
    // Windows are in edge numbers: an output is checked after edge cyc.
    int busy_from[2] = '{-1, -1};
    int busy_to[2]   = '{-2, -2};
    int rdy_from[2]  = '{-1, -1};
    int rdy_to[2]    = '{-2, -2};
    int done_at[2]   = '{-1, -1};
    int pend_magic[2], pend_uniq[2], pend_eq[2], pend_rng[2], pend_mc[2];
    int cur_magic[2] = '{0, 0};
    int cur_uniq[2]  = '{0, 0};
    int cur_eq[2]    = '{0, 0};
    int cur_rng[2]   = '{0, 0};
    int cur_mc[2]    = '{0, 0};
    int lit_on[2]    = '{0, 0};
    int lit_magic[2], lit_uniq[2], lit_eq[2], lit_mc[2];

    int n_vec = 0;
    int n_mis = 0;

    function automatic int side(input int d);
        return (d == 0) ? 3 : 4;
    endfunction

    // Results straight from the definition of a magic square.
    function automatic void model(input int d, input int cells[16]);
        int n, v, dg, an, eq, uq, rg;
        int rs[4];
        int cs[4];
        n = side(d);
        dg = 0; an = 0; eq = 1; uq = 1; rg = 1;
        for (int i = 0; i < 4; i++) begin
            rs[i] = 0;
            cs[i] = 0;
        end
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                v = cells[r * n + c];
                rs[r] += v;
                cs[c] += v;
                if (r == c) dg += v;
                if (r + c == n - 1) an += v;
                if (v < 1 || v > n * n) rg = 0;
            end
        end
        for (int i = 0; i < n * n; i++)
            for (int j = 0; j < i; j++)
                if (cells[i] == cells[j]) uq = 0;
        for (int i = 0; i < n; i++)
            if (rs[i] != rs[0] || cs[i] != rs[0]) eq = 0;
        if (dg != rs[0] || an != rs[0]) eq = 0;
        pend_eq[d]   = eq;
        pend_uniq[d] = uq;
        pend_rng[d]  = rg;
        pend_mc[d]   = rs[0];
`ifdef MAGIC_RANGE_CHECK_EN
        pend_magic[d] = eq & uq & rg;
`else
        pend_magic[d] = eq & uq;
`endif
    endfunction

    task automatic chk(input int d, input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL dut%0d %s at edge %0d: got %0d, expected %0d", d, name, cyc, act, exp);
        end
    endtask

    // Single compare process: every output of both instances, every cycle.
    initial begin
        int a_rdy, a_busy, a_done, a_magic, a_uniq, a_eq, a_mc, a_rng;
        forever begin
            @(negedge clock);
            if (reset) begin
                for (int d = 0; d < 2; d++) begin
                    cur_magic[d] = 0; cur_uniq[d] = 0; cur_eq[d] = 0;
                    cur_rng[d] = 0; cur_mc[d] = 0;
                end
            end
            for (int d = 0; d < 2; d++) begin
                a_rng = 0;
                if (d == 0) begin
                    a_rdy = int'(ready3); a_busy = int'(busy3); a_done = int'(done3);
                    a_magic = int'(magic3); a_uniq = int'(uniq3); a_eq = int'(eq3);
                    a_mc = int'(mc3);
`ifdef MAGIC_RANGE_CHECK_EN
                    a_rng = int'(rok3);
`endif
                end else begin
                    a_rdy = int'(ready4); a_busy = int'(busy4); a_done = int'(done4);
                    a_magic = int'(magic4); a_uniq = int'(uniq4); a_eq = int'(eq4);
                    a_mc = int'(mc4);
`ifdef MAGIC_RANGE_CHECK_EN
                    a_rng = int'(rok4);
`endif
                end
                if (cyc == done_at[d]) begin
                    cur_magic[d] = pend_magic[d]; cur_uniq[d] = pend_uniq[d];
                    cur_eq[d] = pend_eq[d]; cur_rng[d] = pend_rng[d]; cur_mc[d] = pend_mc[d];
                    if (lit_on[d] != 0) begin
                        chk(d, "lit_magic", a_magic, lit_magic[d]);
                        chk(d, "lit_unique", a_uniq, lit_uniq[d]);
                        chk(d, "lit_sums_equal", a_eq, lit_eq[d]);
                        chk(d, "lit_magic_constant", a_mc, lit_mc[d]);
                    end
                end
                chk(d, "done", a_done, (cyc == done_at[d]) ? 1 : 0);
                chk(d, "busy", a_busy, (cyc >= busy_from[d] && cyc <= busy_to[d]) ? 1 : 0);
                chk(d, "cell_ready", a_rdy, (cyc >= rdy_from[d] && cyc < rdy_to[d]) ? 1 : 0);
                chk(d, "it_is_magic", a_magic, cur_magic[d]);
                chk(d, "all_unique", a_uniq, cur_uniq[d]);
                chk(d, "sums_equal", a_eq, cur_eq[d]);
                chk(d, "magic_constant", a_mc, cur_mc[d]);
`ifdef MAGIC_RANGE_CHECK_EN
                chk(d, "range_ok", a_rng, cur_rng[d]);
`else
                a_rng = a_rng;
`endif
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input int d, input bit st, input bit vl, input int dat);
        if (d == 0) begin
            start3 = st; valid3 = vl; data3 = 4'(dat);
        end else begin
            start4 = st; valid4 = vl; data4 = 5'(dat);
        end
    endtask

    task automatic open_square(input int d);
        set_in(d, 1'b1, 1'b0, 0);
        tick;
        busy_from[d] = cyc; busy_to[d] = BIG;
        rdy_from[d] = cyc; rdy_to[d] = BIG;
        done_at[d] = -1;
        set_in(d, 1'b0, 1'b0, 0);
    endtask

    // Full square: optional 2-cycle valid drops after cells gap_a/gap_b (1-based),
    // optional start pulses landing in CHECK and in DONE.
    task automatic run_square(input int d, input int cells[16], input int gap_a,
                              input int gap_b, input bit st_check, input bit st_done);
        int n, last;
        n = side(d);
        open_square(d);
        for (int k = 0; k < n * n; k++) begin
            set_in(d, 1'b0, 1'b1, cells[k]);
            tick;
            if (k + 1 == gap_a || k + 1 == gap_b) begin
                set_in(d, 1'b0, 1'b0, 13);
                repeat (2) tick;
            end
        end
        last = cyc;
        set_in(d, 1'b0, 1'b0, 0);
        rdy_to[d] = last;
        done_at[d] = last + n + 1;
        busy_to[d] = done_at[d];
        model(d, cells);
        if (st_check) begin
            tick;
            set_in(d, 1'b1, 1'b0, 0);
            tick;
            set_in(d, 1'b0, 1'b0, 0);
        end
        while (cyc < done_at[d]) tick;
        if (st_done) begin
            set_in(d, 1'b1, 1'b0, 0);
            tick;
            set_in(d, 1'b0, 1'b0, 0);
        end
        repeat (3) tick;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            busy_from[d] = -1; busy_to[d] = -2;
            rdy_from[d] = -1; rdy_to[d] = -2;
            done_at[d] = -1;
        end
        repeat (2) tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic set_lit(input int d, input int mg, input int uq, input int eq, input int mc);
        lit_on[d] = 1; lit_magic[d] = mg; lit_uniq[d] = uq; lit_eq[d] = eq; lit_mc[d] = mc;
    endtask

    initial begin
        int sq[16];
        do_reset;

        sq = '{2, 7, 6, 9, 5, 1, 4, 3, 8, 0, 0, 0, 0, 0, 0, 0};
        set_lit(0, 1, 1, 1, 15);
        run_square(0, sq, 0, 0, 1'b1, 1'b1);

        sq = '{6, 1, 8, 7, 5, 3, 2, 9, 4, 0, 0, 0, 0, 0, 0, 0};
        set_lit(0, 1, 1, 1, 15);
        run_square(0, sq, 3, 7, 1'b0, 1'b0);

        sq = '{9, 2, 4, 6, 1, 7, 3, 7, 9, 0, 0, 0, 0, 0, 0, 0};
        set_lit(0, 0, 0, 0, 15);
        run_square(0, sq, 0, 0, 1'b0, 1'b0);

        sq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        set_lit(0, 0, 0, 1, 0);
        run_square(0, sq, 0, 0, 1'b0, 1'b0);

        // Reset part-way through a load, then a clean reload.
        sq = '{2, 7, 6, 9, 5, 1, 4, 3, 8, 0, 0, 0, 0, 0, 0, 0};
        open_square(0);
        for (int k = 0; k < 5; k++) begin
            set_in(0, 1'b0, 1'b1, sq[k]);
            tick;
        end
        set_in(0, 1'b0, 1'b0, 0);
        do_reset;
        set_lit(0, 1, 1, 1, 15);
        run_square(0, sq, 0, 0, 1'b1, 1'b0);

        sq = '{16, 3, 2, 13, 5, 10, 11, 8, 9, 6, 7, 12, 4, 15, 14, 1};
        set_lit(1, 1, 1, 1, 34);
        run_square(1, sq, 0, 0, 1'b0, 1'b1);

        repeat (2) tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
